// File: rtl/irq_ctl_if.sv
// rtl/irq_ctl_if.sv - CPU bus signals shared between the 65C02 core and irq_ctl
interface irq_ctl_if;
  logic        RDY;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DB_W;
  logic [7:0]  DB_R;
  logic        sel;

  modport master (output RDY, AB, WE, DB_W, input DB_R, sel);
  modport slave  (input RDY, AB, WE, DB_W, output DB_R, sel);
endinterface

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - level/edge interrupt controller with IRQ/NMI outputs and acknowledging vector read
module irq_ctl #(
  parameter int          CHANNELS = 8,
  parameter logic [15:0] BASE     = 16'hFE00
) (
  input  logic                clk,
  input  logic                RST,
  irq_ctl_if.slave            bus,
  input  logic [CHANNELS-1:0] src,
  output logic                IRQ,
  output logic                NMI
);

  localparam logic [16:0] MASK17  = (17'd1 << CHANNELS) - 17'd1;
  localparam logic [15:0] CH_MASK = MASK17[15:0];

  logic [15:0] s1_q, s2_q, s3_q;
  logic [15:0] edge_pend_q, edge_pend_d;
  logic [15:0] en_q, en_d;
  logic [15:0] mode_q, mode_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        irq_q, nmi_q;
  logic [7:0]  db_r_q, db_r_d;
  logic        sel_q, sel_d;

  logic [15:0] src_ext;
  logic [15:0] pending;
  logic [15:0] active;
  logic        win_any;
  logic [3:0]  win_idx;
  logic [7:0]  vector;
  logic        hit, wr, rd;
  logic [2:0]  addr;
  logic [15:0] clr;
  logic [7:0]  rdata;

  assign src_ext = 16'(src) & CH_MASK;

  // Edge-mode bits come from the sticky flop; level-mode bits are the live synchronized input.
  assign pending = (mode_q & edge_pend_q) | (~mode_q & s2_q);
  assign active  = pending & en_q & ~{15'b0, ctrl_q[1]};

  always_comb begin
    win_any = 1'b0;
    win_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) begin
        win_any = 1'b1;
        win_idx = 4'(i);
      end
    end
  end

  assign vector = win_any ? {1'b1, 2'b00, win_idx, 1'b0} : 8'h00;

  assign addr = bus.AB[2:0];
  assign hit  = bus.RDY && (bus.AB[15:3] == BASE[15:3]);
  assign wr   = hit && bus.WE;
  assign rd   = hit && !bus.WE;

  always_comb begin
    clr = 16'h0000;
    if (wr && addr == 3'd0) clr = {8'h00, bus.DB_W} & mode_q;
    if (wr && addr == 3'd1) clr = {bus.DB_W, 8'h00} & mode_q;
    if (rd && addr == 3'd6 && win_any && mode_q[win_idx]) clr = 16'h0001 << win_idx;
  end

  // Set is OR'd in after the clear so a same-cycle edge always survives.
  assign edge_pend_d = ((edge_pend_q & ~clr) | (s2_q & ~s3_q)) & CH_MASK;

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    ctrl_d = ctrl_q;
    if (wr) begin
      case (addr)
        3'd2:    en_d[7:0]    = bus.DB_W;
        3'd3:    en_d[15:8]   = bus.DB_W;
        3'd4:    mode_d[7:0]  = bus.DB_W;
        3'd5:    mode_d[15:8] = bus.DB_W;
        3'd7:    ctrl_d       = bus.DB_W[1:0];
        default: ;
      endcase
    end
    en_d   = en_d & CH_MASK;
    mode_d = mode_d & CH_MASK;
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      3'd0: rdata = pending[7:0];
      3'd1: rdata = pending[15:8];
      3'd2: rdata = en_q[7:0];
      3'd3: rdata = en_q[15:8];
      3'd4: rdata = mode_q[7:0];
      3'd5: rdata = mode_q[15:8];
      3'd6: rdata = vector;
      3'd7: rdata = {6'b000000, ctrl_q};
    endcase
  end

  always_comb begin
    db_r_d = db_r_q;
    sel_d  = sel_q;
    if (rd) begin
      db_r_d = rdata;
      sel_d  = 1'b1;
    end else if (bus.RDY) begin
      sel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      s1_q        <= 16'h0000;
      s2_q        <= 16'h0000;
      s3_q        <= 16'h0000;
      edge_pend_q <= 16'h0000;
      en_q        <= 16'h0000;
      mode_q      <= 16'h0000;
      ctrl_q      <= 2'b00;
      irq_q       <= 1'b0;
      nmi_q       <= 1'b0;
      db_r_q      <= 8'h00;
      sel_q       <= 1'b0;
    end else begin
      s1_q        <= src_ext;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      edge_pend_q <= edge_pend_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      ctrl_q      <= ctrl_d;
      irq_q       <= ctrl_q[0] & (|active);
      nmi_q       <= ctrl_q[1] & pending[0] & en_q[0];
      db_r_q      <= db_r_d;
      sel_q       <= sel_d;
    end
  end

  assign IRQ      = irq_q;
  assign NMI      = nmi_q;
  assign bus.DB_R = db_r_q;
  assign bus.sel  = sel_q;

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - scoreboard bench for irq_ctl with directed vectors
module tb_irq_ctl;
  localparam logic [15:0] BASE = 16'hFE00;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] src;
  logic       IRQ, NMI;
  logic       prev_rdy = 1'b0;

  irq_ctl_if bus ();

  irq_ctl #(.CHANNELS(8), .BASE(BASE)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus),
    .src (src),
    .IRQ (IRQ),
    .NMI (NMI)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] data;
  } rd_t;

  rd_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // DB_R is fresh only when the edge that loaded it had RDY=1.
  always @(posedge clk) prev_rdy <= bus.RDY;

  always @(negedge clk) begin
    rd_t e;
    if (bus.sel && prev_rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL read_unexpected: got %02h, nothing queued", bus.DB_R);
      end else begin
        e = exp_q.pop_front();
        chk(e.name, bus.DB_R, e.data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    bus.RDY  = 1'b1;
    bus.AB   = BASE + 16'(a);
    bus.WE   = 1'b1;
    bus.DB_W = d;
    tick();
    bus.AB   = 16'h0000;
    bus.WE   = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    rd_t e;
    bus.RDY = 1'b1;
    bus.AB  = BASE + 16'(a);
    bus.WE  = 1'b0;
    e.name  = name;
    e.data  = exp;
    exp_q.push_back(e);
    tick();
    bus.AB  = 16'h0000;
  endtask

  initial begin
    RST      = 1'b0;
    src      = 8'h00;
    bus.RDY  = 1'b1;
    bus.AB   = 16'h0000;
    bus.WE   = 1'b0;
    bus.DB_W = 8'h00;
    tick(2);
    chk("reset_irq", {7'b0, IRQ}, 8'h00);
    chk("reset_nmi", {7'b0, NMI}, 8'h00);
    chk("reset_dbr", bus.DB_R, 8'h00);
    chk("reset_sel", {7'b0, bus.sel}, 8'h00);
    RST = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) bus_rd(3'(i), 8'h00, $sformatf("reset_reg%0d", i));
    tick();

    // Edge priority: channel 5 then channel 2
    bus_wr(3'd2, 8'hFF);
    bus_wr(3'd4, 8'hFF);
    bus_wr(3'd7, 8'h01);
    tick();
    src[5] = 1'b1;
    tick(2);
    src[5] = 1'b0;
    tick();
    chk("edge_irq_k2", {7'b0, IRQ}, 8'h00);
    tick();
    chk("edge_irq_k3", {7'b0, IRQ}, 8'h01);
    src[2] = 1'b1;
    tick(2);
    src[2] = 1'b0;
    tick(3);
    bus_rd(3'd0, 8'h24, "edge_pend");
    bus_rd(3'd6, 8'h84, "edge_vec_ch2");
    bus_rd(3'd6, 8'h8A, "edge_vec_ch5");
    chk("edge_irq_after_ack1", {7'b0, IRQ}, 8'h01);
    bus_rd(3'd6, 8'h00, "edge_vec_none");
    chk("edge_irq_low", {7'b0, IRQ}, 8'h00);
    tick();

    // Level mode on channel 3
    bus_wr(3'd4, 8'h00);
    src[3] = 1'b1;
    tick(3);
    chk("level_irq_high", {7'b0, IRQ}, 8'h01);
    bus_rd(3'd6, 8'h86, "level_vec1");
    bus_rd(3'd6, 8'h86, "level_vec2");
    chk("level_irq_stays", {7'b0, IRQ}, 8'h01);
    bus_wr(3'd0, 8'h08);
    bus_rd(3'd0, 8'h08, "level_w1c_ignored");
    src[3] = 1'b0;
    tick(2);
    chk("level_irq_k2", {7'b0, IRQ}, 8'h01);
    tick();
    chk("level_irq_k3", {7'b0, IRQ}, 8'h00);

    // NMI routing on channel 0
    bus_wr(3'd7, 8'h02);
    bus_wr(3'd2, 8'h01);
    bus_wr(3'd4, 8'h01);
    tick();
    src[0] = 1'b1;
    tick(2);
    src[0] = 1'b0;
    tick();
    chk("nmi_k2", {7'b0, NMI}, 8'h00);
    tick();
    chk("nmi_k3", {7'b0, NMI}, 8'h01);
    chk("nmi_irq_off", {7'b0, IRQ}, 8'h00);
    bus_rd(3'd6, 8'h00, "nmi_vec_excluded");
    bus_wr(3'd0, 8'h01);
    chk("nmi_hold_at_clear", {7'b0, NMI}, 8'h01);
    tick();
    chk("nmi_dropped", {7'b0, NMI}, 8'h00);

    // Set/clear collision on channel 1
    bus_wr(3'd4, 8'h03);
    bus_wr(3'd2, 8'h03);
    src[1] = 1'b1;
    tick(2);
    bus_wr(3'd0, 8'h02);
    bus_rd(3'd0, 8'h02, "collision_set_wins");

    // RDY stall during a VECTOR read
    bus_wr(3'd7, 8'h01);
    bus_wr(3'd2, 8'h02);
    tick();
    chk("stall_irq_high", {7'b0, IRQ}, 8'h01);
    bus_rd(3'd0, 8'h02, "stall_pre_read");
    bus.RDY = 1'b0;
    bus.AB  = BASE + 16'd6;
    tick();
    chk("stall_dbr_hold", bus.DB_R, 8'h02);
    chk("stall_sel_hold", {7'b0, bus.sel}, 8'h01);
    bus_rd(3'd6, 8'h82, "stall_vec_retry");
    bus_rd(3'd0, 8'h00, "stall_pend_cleared");
    chk("stall_irq_low", {7'b0, IRQ}, 8'h00);
    src = 8'h00;
    tick(3);

    // Mode change exposes the edge flop latched while channel 3 was level
    bus_wr(3'd2, 8'hFF);
    bus_wr(3'd4, 8'hFF);
    bus_rd(3'd0, 8'h08, "mode_change_keeps_edge");
    chk("pre_reset_irq", {7'b0, IRQ}, 8'h01);
    tick();
    RST = 1'b0;
    #1;
    chk("async_reset_irq", {7'b0, IRQ}, 8'h00);
    chk("async_reset_nmi", {7'b0, NMI}, 8'h00);
    chk("async_reset_dbr", bus.DB_R, 8'h00);
    chk("async_reset_sel", {7'b0, bus.sel}, 8'h00);
    RST = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) bus_rd(3'(i), 8'h00, $sformatf("post_reset_reg%0d", i));
    tick(3);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_missing: %0d reads never returned, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end
endmodule
